// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encodings, light patterns and default durations
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        RED1 = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        RED2 = 3'd5
    } state_t;

    // light[5:3] = NS {R,Y,G}, light[2:0] = EW {R,Y,G}
    localparam logic [5:0] LIGHT_NS_G = 6'b001_100;
    localparam logic [5:0] LIGHT_NS_Y = 6'b010_100;
    localparam logic [5:0] LIGHT_RED1 = 6'b100_100;
    localparam logic [5:0] LIGHT_EW_G = 6'b100_001;
    localparam logic [5:0] LIGHT_EW_Y = 6'b100_010;
    localparam logic [5:0] LIGHT_RED2 = 6'b100_100;

    localparam int DEF_T_GREEN     = 8;
    localparam int DEF_T_MIN_GREEN = 3;
    localparam int DEF_T_YELLOW    = 2;
    localparam int DEF_T_ALLRED    = 1;

    // Unknown codes decode to all-red so a corrupted state never shows a go aspect
    function automatic logic [5:0] light_of(input state_t s);
        case (s)
            NS_G:    return LIGHT_NS_G;
            NS_Y:    return LIGHT_NS_Y;
            RED1:    return LIGHT_RED1;
            EW_G:    return LIGHT_EW_G;
            EW_Y:    return LIGHT_EW_Y;
            RED2:    return LIGHT_RED2;
            default: return LIGHT_RED2;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-enabled 4-bit phase counter with synchronous clear
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count
);

    // Clear beats enable so the count restarts at 0 on the exiting tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - two-way traffic light sequencer with request-driven early green cut
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    output logic [5:0] light,
    output logic [2:0] phase,
    output logic       ns_ack,
    output logic       ew_ack
);

    // Timer value on the tick that ends each kind of phase
    localparam logic [3:0] GREEN_LAST  = 4'(T_GREEN - 1);
    localparam logic [3:0] MIN_G_LAST  = 4'(T_MIN_GREEN - 1);
    localparam logic [3:0] YELLOW_LAST = 4'(T_YELLOW - 1);
    localparam logic [3:0] ALLRED_LAST = 4'(T_ALLRED - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] count;
    logic       state_chg;
    logic       ns_pend;
    logic       ew_pend;
    logic       ns_pend_nx;
    logic       ew_pend_nx;
    logic       enter_ns;
    logic       enter_ew;
    logic       green_done;

    phase_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_chg),
        .en    (tick),
        .count (count)
    );

    // Next state: timed exits, with greens cut short once the cross direction is waiting
    always_comb begin
        next_state = state;
        green_done = 1'b0;
        case (state)
            NS_G: begin
                green_done = (count == GREEN_LAST) || ((count >= MIN_G_LAST) && ew_pend);
                if (tick && green_done) next_state = NS_Y;
            end
            NS_Y: if (tick && (count == YELLOW_LAST)) next_state = RED1;
            RED1: if (tick && (count == ALLRED_LAST)) next_state = EW_G;
            EW_G: begin
                green_done = (count == GREEN_LAST) || ((count >= MIN_G_LAST) && ns_pend);
                if (tick && green_done) next_state = EW_Y;
            end
            EW_Y: if (tick && (count == YELLOW_LAST)) next_state = RED2;
            RED2: if (tick && (count == ALLRED_LAST)) next_state = NS_G;
            default: next_state = RED2;
        endcase
    end

    // Pending flags: green entry clears and wins over a same-edge request
    always_comb begin
        state_chg  = (next_state != state);
        enter_ns   = state_chg && (next_state == NS_G);
        enter_ew   = state_chg && (next_state == EW_G);
        ns_pend_nx = ns_pend;
        ew_pend_nx = ew_pend;
        if (enter_ns) begin
            ns_pend_nx = 1'b0;
        end else if (ns_req && (state != NS_G)) begin
            ns_pend_nx = 1'b1;
        end
        if (enter_ew) begin
            ew_pend_nx = 1'b0;
        end else if (ew_req && (state != EW_G)) begin
            ew_pend_nx = 1'b1;
        end
    end

    // State, pending flags and outputs all register on the same edge, outputs decoded from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NS_G;
            ns_pend <= 1'b0;
            ew_pend <= 1'b0;
            light   <= LIGHT_NS_G;
            phase   <= 3'd0;
            ns_ack  <= 1'b0;
            ew_ack  <= 1'b0;
        end else begin
            state   <= next_state;
            ns_pend <= ns_pend_nx;
            ew_pend <= ew_pend_nx;
            light   <= light_of(next_state);
            phase   <= next_state;
            ns_ack  <= enter_ns;
            ew_ack  <= enter_ew;
        end
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb/tb_traffic_sequencer.sv - self-checking bench for traffic_sequencer
module tb_traffic_sequencer;

    localparam int TG  = 8;
    localparam int TMG = 3;
    localparam int TY  = 2;
    localparam int TR  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic [5:0] light;
    logic [2:0] phase;
    logic       ns_ack;
    logic       ew_ack;

    int tests = 0;
    int fails = 0;
    int tick_mode = 0;
    int tick_cnt = 0;
    bit rnd_req = 1'b0;

    traffic_sequencer #(
        .T_GREEN     (TG),
        .T_MIN_GREEN (TMG),
        .T_YELLOW    (TY),
        .T_ALLRED    (TR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .ns_req (ns_req),
        .ew_req (ew_req),
        .light  (light),
        .phase  (phase),
        .ns_ack (ns_ack),
        .ew_ack (ew_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        tick_cnt++;
        case (tick_mode)
            0:       tick = 1'b1;
            1:       tick = ((tick_cnt % 4) == 0);
            default: tick = 1'($urandom_range(0, 1));
        endcase
        if (rnd_req) begin
            ns_req = ($urandom_range(0, 7) == 0);
            ew_req = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic measure(input int p, output int n);
        n = 0;
        while ((phase == 3'(p)) && (n < 200)) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_phase_start(input int p);
        int k = 0;
        while ((phase == 3'(p)) && (k < 1000)) begin cyc(); k++; end
        while ((phase != 3'(p)) && (k < 1000)) begin cyc(); k++; end
        if (k >= 1000) begin
            tests++;
            fails++;
            $display("FAIL wait_phase_%0d: timed out, phase=%0d", p, phase);
        end
    endtask

    // Reference model: phase index, ticks spent in it, and per-direction waiting flags
    initial begin
        int         mp = 0;
        int         mt = 0;
        bit         pend_ns = 0, pend_ew = 0, ack_ns = 0, ack_ew = 0;
        bit         prev_ns = 0, prev_ew = 0;
        int         dur[6];
        logic [5:0] ltab[6];
        int         ok;
        bit         leave;
        int         old;
        dur  = '{TG, TY, TR, TG, TY, TR};
        ltab = '{6'b001100, 6'b010100, 6'b100100, 6'b100001, 6'b100010, 6'b100100};
        forever begin
            @(negedge clk);
            if (rst) begin
                mp = 0; mt = 0; pend_ns = 0; pend_ew = 0; ack_ns = 0; ack_ew = 0;
            end
            check("light", light, ltab[mp]);
            check("phase", phase, mp);
            check("ns_ack", ns_ack, ack_ns);
            check("ew_ack", ew_ack, ack_ew);
            check("ns_pend", dut.ns_pend, pend_ns);
            check("ew_pend", dut.ew_pend, pend_ew);
            check("timer", dut.u_timer.count, mt);
            ok = !((light[4] | light[3]) && (light[2:0] != 3'b100)) &&
                 !((light[1] | light[0]) && (light[5:3] != 3'b100));
            check("cross_safety", ok, 1);
            check("ack_width", (prev_ns && ns_ack) || (prev_ew && ew_ack), 0);
            prev_ns = ns_ack;
            prev_ew = ew_ack;
            if (!rst) begin
                leave  = 0;
                ack_ns = 0;
                ack_ew = 0;
                if (tick) begin
                    mt++;
                    if (mp == 0)      leave = (mt == TG) || (mt >= TMG && pend_ew);
                    else if (mp == 3) leave = (mt == TG) || (mt >= TMG && pend_ns);
                    else              leave = (mt == dur[mp]);
                end
                old = mp;
                if (leave) begin
                    mp = (mp + 1) % 6;
                    mt = 0;
                end
                if (leave && mp == 0) begin pend_ns = 0; ack_ns = 1; end
                else if (ns_req && old != 0) pend_ns = 1;
                if (leave && mp == 3) begin pend_ew = 0; ack_ew = 1; end
                else if (ew_req && old != 3) pend_ew = 1;
            end
        end
    end

    initial begin
        int n, m, tot;
        int exp_len[6];
        exp_len = '{8, 2, 1, 8, 2, 1};

        // Reset state
        rst = 1'b1;
        repeat (3) cyc();
        check("rst_light", light, 6'b001100);
        check("rst_phase", phase, 0);
        check("rst_ns_ack", ns_ack, 0);
        check("rst_ew_ack", ew_ack, 0);
        rst = 1'b0;

        // Default cycle, tick every cycle, no requests
        tot = 0;
        for (int p = 0; p < 6; p++) begin
            if (p == 0) begin
                cyc();
                check("release_no_ack", ns_ack, 0);
                measure(0, n);
                n = n + 1;
            end else begin
                measure(p, n);
            end
            check($sformatf("len_default_p%0d", p), n, exp_len[p]);
            tot += n;
        end
        check("period_default", tot, 22);
        check("wrap_phase", phase, 0);
        check("wrap_ns_ack", ns_ack, 1);

        // EW request during first NS_G tick cuts green after 3 ticks
        ew_req = 1'b1;
        cyc();
        ew_req = 1'b0;
        measure(0, m);
        check("len_cut_ns_g", m + 1, 3);
        measure(1, n);
        check("len_cut_ns_y", n, 2);
        measure(2, n);
        check("len_cut_red1", n, 1);
        check("ew_ack_on_entry", ew_ack, 1);
        check("ew_pend_cleared", dut.ew_pend, 0);
        measure(3, n);
        check("len_ew_g_full", n, 8);
        measure(4, n);
        measure(5, n);

        // NS request held through NS_G is ignored
        check("at_ns_g", phase, 0);
        ns_req = 1'b1;
        measure(0, n);
        ns_req = 1'b0;
        check("len_ns_g_held_req", n, 8);
        check("ns_pend_stays_0", dut.ns_pend, 0);

        // Tick every 4th cycle scales each phase by 4
        tick_mode = 1;
        wait_phase_start(0);
        for (int p = 0; p < 6; p++) begin
            measure(p, n);
            check($sformatf("len_div4_p%0d", p), n, 4 * exp_len[p]);
        end

        // Asynchronous reset in the middle of EW_Y
        tick_mode = 0;
        wait_phase_start(4);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_light", light, 6'b001100);
        check("async_rst_phase", phase, 0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        check("rerelease_no_ack", ns_ack, 0);
        measure(0, n);
        check("len_ns_g_after_rst", n + 1, 8);

        // Random ticks and requests
        tick_mode = 2;
        rnd_req = 1'b1;
        repeat (10000) cyc();
        rnd_req = 1'b0;
        ns_req = 1'b0;
        ew_req = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_sequencer.md
TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 Parameter T_GREEN, default 8: full green duration, in ticks.
REQ-002 Parameter T_MIN_GREEN, default 3: minimum green before an early cut, in ticks; SHALL satisfy 1 <= T_MIN_GREEN <= T_GREEN.
REQ-003 Parameter T_YELLOW, default 2: yellow duration, in ticks.
REQ-004 Parameter T_ALLRED, default 1: all-red clearance duration, in ticks; all durations SHALL be 1..15.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tick  input  1  single-cycle timing enable; all phase timing counts only on cycles with tick=1.
REQ-008 ns_req  input  1  north-south vehicle/pedestrian request, sampled every cycle.
REQ-009 ew_req  input  1  east-west request, sampled every cycle.
REQ-010 light  output  6  [5:3] = NS {R,Y,G}, [2:0] = EW {R,Y,G}, one-hot per direction, registered.
REQ-011 phase  output  3  current state encoding, registered.
REQ-012 ns_ack / ew_ack  output  1 each  one-cycle pulse when that direction's green begins.

Function
REQ-013 States SHALL be NS_G=0, NS_Y=1, RED1=2, EW_G=3, EW_Y=4, RED2=5, visited in cyclic order NS_G->NS_Y->RED1->EW_G->EW_Y->RED2->NS_G; codes 6 and 7 SHALL go to RED2 on the next edge.
REQ-014 Light per state: NS_G=001_100, NS_Y=010_100, RED1=100_100, EW_G=100_001, EW_Y=100_010, RED2=100_100.
REQ-015 A 4-bit phase timer SHALL clear to 0 on every state change and increment on each tick; it SHALL not change without a tick.
REQ-016 A non-green state SHALL exit on the tick where timer == duration-1.
REQ-017 A green state SHALL exit on the tick where timer == T_GREEN-1, or earlier on the first tick where timer >= T_MIN_GREEN-1 and the cross-direction pending flag is set.
REQ-018 ns_req=1 SHALL set ns_pend, except while in NS_G, where it is ignored; ew_req and ew_pend SHALL behave symmetrically in EW_G.
REQ-019 On the edge entering NS_G, ns_pend SHALL clear and ns_ack SHALL pulse high for exactly one cycle; EW behaves symmetrically.
REQ-020 If a request arrives on the same edge its flag clears on green entry, clearing SHALL win and the request is dropped.
REQ-021 If a request arrives on the same cycle as a qualifying tick, it SHALL not shorten the green on that tick; the flag is visible from the next cycle.
REQ-022 light and phase SHALL change on the same clock edge that samples the exiting tick (latency 1 cycle from tick).
REQ-023 No direction SHALL ever show G or Y while the other shows anything but R.

Reset
REQ-024 While rst=1: state=NS_G, timer=0, ns_pend=ew_pend=0, light=001_100, phase=0, ns_ack=ew_ack=0.
REQ-025 Reset asserted mid-phase SHALL take effect immediately, without waiting for clk.
REQ-026 ns_ack SHALL not pulse on reset release.

Structure
REQ-027 Shared package traffic_pkg SHALL hold the state encodings, the six light encodings and the default durations.
REQ-028 The tick-enabled counter SHALL be one sub-module, phase_timer (inputs clk, rst, clr, en; output 4-bit count).
REQ-029 The next-state logic and pending/ack logic SHALL be combinational around a single registered state; outputs SHALL be decoded from state and registered.

Verification
REQ-030 Defaults, tick every cycle, no requests -> NS_G held 8 ticks, NS_Y 2, RED1 1, EW_G 8, EW_Y 2, RED2 1; period 22 cycles.
REQ-031 ew_req pulsed on tick 1 of NS_G -> NS_Y entered after tick 3; ew_ack pulses on the EW_G entry edge; ew_pend is 0 afterward.
REQ-032 ns_req held high throughout NS_G -> ns_pend stays 0; NS_G lasts the full 8 ticks.
REQ-033 tick every 4th cycle -> every phase length scales by 4x in cycles; timer holds between ticks.
REQ-034 rst asserted mid-EW_Y, between clock edges -> light=001_100 immediately; after release, the first NS_G lasts 8 ticks.
REQ-035 Random req/tick for 10k cycles -> REQ-023 assertion never fires; each ack is exactly one cycle wide.
